ballot_input_controller: RTL
============================

# ballot_input_controller

Front-end ballot stage feeding `memory_control_unit`: turns raw voter-ID entry and candidate/confirm/cancel buttons into one clean, registered vote transaction. It drives `voter_number`, `candidate_number` and a single-cycle `vote_signal` pulse downstream. It also enforces select → confirm → cast sequencing, a post-cast cooldown, and an optional inactivity timeout. Duplicate-voter rejection remains downstream; this block only guarantees well-formed, one-shot casts.

## Interface
- `N_CAND`, 4 — number of candidates; one button each.
- `CAND_W`, 2 — candidate index width, equal to clog2(`N_CAND`).
- `VOTER_W`, 3 — voter ID width.
- `COOLDOWN_CYCLES`, 4 — cycles spent in HOLD after a cast; minimum 1.
- `TIMEOUT_CYCLES`, 16 — inactivity limit in SELECT/CONFIRM; used only with `BALLOT_TIMEOUT_EN`.

Ports:
- `clk` in 1 — single clock; all state updates on the rising edge.
- `rst` in 1 — synchronous, active-high reset.
- `voter_id_in` in `VOTER_W` — voter ID from the authentication keypad.
- `voter_id_valid` in 1 — level; sampled in IDLE only.
- `cand_btn` in `N_CAND` — level candidate buttons, bit i is candidate i.
- `confirm_btn` in 1 — level confirm button.
- `cancel_btn` in 1 — level cancel button.
- `voter_number` out `VOTER_W` — latched voter ID to the memory unit.
- `candidate_number` out `CAND_W` — latched candidate index to the memory unit.
- `vote_signal` out 1 — one-cycle cast strobe to the memory unit.
- `ready` out 1 — high in IDLE.
- `busy` out 1 — high in CAST and HOLD.
- `err` out 1 — one-cycle pulse when an ambiguous candidate press is rejected.
- `timeout` out 1 — one-cycle pulse when the inactivity abort fires.

## Operation
- FSM states: IDLE, SELECT, CONFIRM, CAST, HOLD.
- Buttons are edge-detected. `rise = btn & ~btn_q`, where `btn_q` is the previous cycle's sample. Only rising edges act; held levels do nothing.
- IDLE → SELECT: when `voter_id_valid` is high. `voter_id_in` is latched into `voter_number`. In any other state, `voter_id_valid` is ignored.
- SELECT → CONFIRM: on a candidate rise with exactly one bit set. The encoded index is latched into `candidate_number`.
- Candidate rise with more than one bit set: `err` pulses and the state is unchanged.
- CONFIRM, new single candidate rise: `candidate_number` is re-latched and the state stays CONFIRM.
- CONFIRM → CAST: on a `confirm_btn` rise.
- SELECT or CONFIRM → IDLE: on a `cancel_btn` rise. No vote is cast. Cancel has priority over confirm and over candidate rises in the same cycle.
- `confirm_btn` rise in SELECT: ignored.
- CAST: lasts exactly one cycle with `vote_signal`=1, then HOLD.
- HOLD: lasts `COOLDOWN_CYCLES` cycles, then IDLE. All button rises and `voter_id_valid` are ignored.
- `voter_number` and `candidate_number` hold their values from the CAST cycle through the end of HOLD. They change only on a new latch.
- All outputs are registered. No combinational path from any input to any output.

## Timing
- Reset values:
  - state IDLE, `ready`=1.
  - `vote_signal`, `busy`, `err`, `timeout` = 0.
  - `voter_number`, `candidate_number` = 0.
  - Cooldown and timeout counters = 0.
  - All `btn_q` = 1, so a button held through reset does not fire on release of `rst`.
- Latencies, for an event sampled at edge N:
  - `voter_id_valid`: SELECT and `ready`=0 from N+1.
  - Confirm rise: `vote_signal`=1 for cycle N+1 only.
  - HOLD occupies N+2 through N+1+`COOLDOWN_CYCLES`. `ready`=1 from N+2+`COOLDOWN_CYCLES`.
- `err` and `timeout` appear the cycle after their cause, for one cycle.
- Reset asserted in any state, including CAST: `vote_signal` is 0 at the next edge and the FSM goes to IDLE. No partial cast is emitted.
- Cooldown counter counts 0..`COOLDOWN_CYCLES`-1 and has no wrap-around. Its width is clog2(`COOLDOWN_CYCLES`+1).

## Configuration
- `BALLOT_TIMEOUT_EN` defined:
  - The counter clears on entry to SELECT and on every accepted candidate rise.
  - It increments each cycle in SELECT/CONFIRM.
  - On reaching `TIMEOUT_CYCLES`-1, the FSM returns to IDLE and `timeout` pulses.
  - If cancel and expiry coincide, cancel wins and `timeout` stays 0.
- `BALLOT_TIMEOUT_EN` undefined: no counter is compiled in, `timeout` is tied to 0, and SELECT/CONFIRM wait indefinitely.

## Structure
- Package `ballot_pkg` holds:
  - The state enum (IDLE, SELECT, CONFIRM, CAST, HOLD).
  - Default widths `CAND_W`/`VOTER_W`, shared with `memory_control_unit`.
  - The one-hot-to-index function with a valid flag for exactly one bit set.
- One sub-module, `edge_detect`: parameterized-width rising-edge detector with reset-to-ones history. It is instantiated once over {`cancel_btn`, `confirm_btn`, `cand_btn`}.

## Test plan
- Full vote: reset; `voter_id_in`=3, valid 1 cycle; `cand_btn`=4'b0100 rise; confirm rise → exactly one `vote_signal` cycle with `voter_number`=3, `candidate_number`=2; `busy` for 1+4 cycles; then `ready`=1.
- Re-select: candidate 1 rise, then candidate 0 rise in CONFIRM, then confirm → cast with `candidate_number`=0.
- Ambiguous or cancel: `cand_btn`=4'b0011 rise → `err` pulse, state SELECT. Cancel and confirm rising together in CONFIRM → IDLE, no `vote_signal`.
- Cooldown lockout: `voter_id_valid` and button rises during HOLD → ignored; the next voter is accepted only after `ready` returns.
- Reset mid-flow: `rst` in the CAST cycle → `vote_signal`=0 next edge, IDLE. Confirm held through reset → no cast after reset.
- With `BALLOT_TIMEOUT_EN`: voter valid, then idle 16 cycles → `timeout` pulse, IDLE, no cast. A candidate rise at cycle 10 restarts the count.

Source files
------------

// File: rtl/ballot_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ballot_pkg
// Description : Shared ballot types, default widths and one-hot decoding.
// Revision    : 1.0 - initial release
// ============================================================================
package ballot_pkg;

    localparam int CAND_W  = 2;
    localparam int VOTER_W = 3;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SELECT  = 3'd1,
        ST_CONFIRM = 3'd2,
        ST_CAST    = 3'd3,
        ST_HOLD    = 3'd4
    } ballot_state_t;

    // Returns {exactly_one_bit_set, index_of_highest_set_bit}.
    function automatic logic [8:0] onehot_to_index(input logic [31:0] vec);
        logic [7:0] idx;
        int         cnt;
        idx = '0;
        cnt = 0;
        for (int i = 0; i < 32; i++) begin
            if (vec[i]) begin
                idx = 8'(i);
                cnt = cnt + 1;
            end
        end
        return {(cnt == 1), idx};
    endfunction

endpackage
`default_nettype wire

// File: rtl/edge_detect.sv
`default_nettype none
// ============================================================================
// Module      : edge_detect
// Description : Rising-edge detector; history resets to ones so levels held
//               through reset do not fire.
// Revision    : 1.0 - initial release
// ============================================================================
module edge_detect #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] sig,
    output logic [WIDTH-1:0] rise
);

    logic [WIDTH-1:0] r_hist;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_hist <= '1;
        end else begin
            r_hist <= sig;
        end
    end

    assign rise = sig & ~r_hist;

endmodule
`default_nettype wire

// File: rtl/ballot_input_controller.sv
`default_nettype none
// ============================================================================
// Module      : ballot_input_controller
// Description : Turns voter-ID entry and button presses into one registered,
//               one-shot vote transaction. Optional macro BALLOT_TIMEOUT_EN
//               adds an inactivity abort in SELECT/CONFIRM.
// Revision    : 1.0 - initial release
// ============================================================================
module ballot_input_controller #(
    parameter int N_CAND          = 4,
    parameter int CAND_W          = ballot_pkg::CAND_W,
    parameter int VOTER_W         = ballot_pkg::VOTER_W,
    parameter int COOLDOWN_CYCLES = 4,
    parameter int TIMEOUT_CYCLES  = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [VOTER_W-1:0] voter_id_in,
    input  logic               voter_id_valid,
    input  logic [N_CAND-1:0]  cand_btn,
    input  logic               confirm_btn,
    input  logic               cancel_btn,
    output logic [VOTER_W-1:0] voter_number,
    output logic [CAND_W-1:0]  candidate_number,
    output logic               vote_signal,
    output logic               ready,
    output logic               busy,
    output logic               err,
    output logic               timeout
);
    import ballot_pkg::*;

    localparam int CD_W = $clog2(COOLDOWN_CYCLES + 1);

    logic [N_CAND+1:0]  w_rise;
    logic [N_CAND-1:0]  w_cand_rise;
    logic               w_confirm_rise;
    logic               w_cancel_rise;
    logic [8:0]         w_dec;
    logic               w_cand_one;
    logic               w_cand_any;
    logic [CAND_W-1:0]  w_cand_idx;
    logic               w_expire;

    ballot_state_t      r_state;
    logic [CD_W-1:0]    r_cool;
    logic [VOTER_W-1:0] r_voter;
    logic [CAND_W-1:0]  r_cand;
    logic               r_vote;
    logic               r_ready;
    logic               r_busy;
    logic               r_err;

    edge_detect #(
        .WIDTH (N_CAND + 2)
    ) u_edge (
        .clk  (clk),
        .rst  (rst),
        .sig  ({cancel_btn, confirm_btn, cand_btn}),
        .rise (w_rise)
    );

    assign w_cand_rise    = w_rise[N_CAND-1:0];
    assign w_confirm_rise = w_rise[N_CAND];
    assign w_cancel_rise  = w_rise[N_CAND+1];
    assign w_dec          = onehot_to_index(32'(w_cand_rise));
    assign w_cand_one     = w_dec[8];
    assign w_cand_any     = |w_cand_rise;
    assign w_cand_idx     = w_dec[CAND_W-1:0];

`ifdef BALLOT_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TO_W-1:0] r_tcnt;
    logic            r_timeout;
    assign w_expire = (r_tcnt == TO_W'(TIMEOUT_CYCLES - 1));
    assign timeout  = r_timeout;
`else
    assign w_expire = 1'b0;
    assign timeout  = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_cool  <= '0;
            r_voter <= '0;
            r_cand  <= '0;
            r_vote  <= 1'b0;
            r_ready <= 1'b1;
            r_busy  <= 1'b0;
            r_err   <= 1'b0;
`ifdef BALLOT_TIMEOUT_EN
            r_tcnt    <= '0;
            r_timeout <= 1'b0;
`endif
        end else begin
            r_vote <= 1'b0;
            r_err  <= 1'b0;
`ifdef BALLOT_TIMEOUT_EN
            r_timeout <= 1'b0;
`endif
            case (r_state)
                ST_IDLE: begin
                    if (voter_id_valid) begin
                        r_voter <= voter_id_in;
                        r_state <= ST_SELECT;
                        r_ready <= 1'b0;
`ifdef BALLOT_TIMEOUT_EN
                        r_tcnt  <= '0;
`endif
                    end
                end
                ST_SELECT, ST_CONFIRM: begin
                    // Cancel outranks expiry, which outranks any button activity.
                    if (w_cancel_rise) begin
                        r_state <= ST_IDLE;
                        r_ready <= 1'b1;
                    end else if (w_expire) begin
                        r_state <= ST_IDLE;
                        r_ready <= 1'b1;
`ifdef BALLOT_TIMEOUT_EN
                        r_timeout <= 1'b1;
`endif
                    end else begin
`ifdef BALLOT_TIMEOUT_EN
                        r_tcnt <= r_tcnt + TO_W'(1);
`endif
                        if (r_state == ST_CONFIRM && w_confirm_rise) begin
                            r_state <= ST_CAST;
                            r_vote  <= 1'b1;
                            r_busy  <= 1'b1;
                        end else if (w_cand_one) begin
                            r_cand  <= w_cand_idx;
                            r_state <= ST_CONFIRM;
`ifdef BALLOT_TIMEOUT_EN
                            r_tcnt  <= '0;
`endif
                        end else if (w_cand_any) begin
                            r_err <= 1'b1;
                        end
                    end
                end
                ST_CAST: begin
                    r_state <= ST_HOLD;
                    r_cool  <= '0;
                end
                ST_HOLD: begin
                    if (r_cool == CD_W'(COOLDOWN_CYCLES - 1)) begin
                        r_state <= ST_IDLE;
                        r_ready <= 1'b1;
                        r_busy  <= 1'b0;
                    end else begin
                        r_cool <= r_cool + CD_W'(1);
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_ready <= 1'b1;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign voter_number     = r_voter;
    assign candidate_number = r_cand;
    assign vote_signal      = r_vote;
    assign ready            = r_ready;
    assign busy             = r_busy;
    assign err              = r_err;

endmodule
`default_nettype wire
